alu_operand_regfile: RTL and testbench
======================================

Name: alu_operand_regfile

Overview:
- Register-file and sequencing stage that sits directly upstream of the combinational ALU.
- Accepts one instruction per handshake and reads two source registers onto the ALU operand/opcode inputs.
- Captures the ALU result the same cycle, then writes it back to the destination register and reports the write.
- Gives the ALU a clocked home: operand storage, write-back, zero flag and illegal-opcode detection.

Parameters:
- NUM_REGS, 4, number of 8-bit general registers; power of two, ≥2.
- AW, 2, register index width; equals log2(NUM_REGS).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  upstream has an instruction.
- instr_ready  output  1  block can accept an instruction.
- instr_ld_imm  input  1  1 = load imm into rd, bypassing the ALU.
- instr_op  input  3  ALU opcode (000 AND, 001 OR, 010 ADD, 011 SUB, 100 INC, 101 DEC).
- instr_rd  input  AW  destination register index.
- instr_rs1  input  AW  source register index for operand a.
- instr_rs2  input  AW  source register index for operand b.
- instr_imm  input  8  immediate value.
- alu_a  output  8  operand a to ALU.
- alu_b  output  8  operand b to ALU.
- alu_opcode  output  3  opcode to ALU.
- alu_result  input  8  combinational ALU result.
- wb_valid  output  1  one-cycle pulse: register write performed.
- wb_addr  output  AW  register written.
- wb_data  output  8  value written.
- zero_flag  output  1  1 when the last written value was 8'h00.
- illegal_op  output  1  sticky; set by a non-immediate instruction with opcode 110 or 111.
- dbg_addr  input  AW  debug read index.
- dbg_data  output  8  combinational read of regs[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; all regs = 8'h00; captured instruction fields = 0; result register = 0.
  - Outputs: wb_valid=0, wb_addr=0, wb_data=0, zero_flag=0, illegal_op=0, instr_ready=1 once released.
  - Reset mid-instruction abandons it: no write, no wb_valid pulse.
- State machine: IDLE -> EXEC -> WB -> IDLE; one instruction every 3 cycles.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready, capture ld_imm, op, rd, rs1, rs2, imm into the instruction register and go to EXEC.
  - With instr_valid=0, stay in IDLE.
- EXEC:
  - instr_ready=0; alu_a=regs[rs1_q], alu_b=regs[rs2_q], alu_opcode=op_q.
  - At the clock edge, result_q <= ld_imm_q ? imm_q : alu_result; go to WB.
  - If !ld_imm_q and op_q ∈ {110,111}, set illegal_op. The result (ALU returns 0) is still written.
- WB:
  - instr_ready=0; at the clock edge regs[rd_q] <= result_q.
  - wb_valid=1 for the cycle following that edge, with wb_addr=rd_q, wb_data=result_q and zero_flag=(result_q==0).
  - The state is IDLE during that pulse cycle, so the next instruction may be accepted in the same cycle.
- Operand outputs outside EXEC: alu_a=0, alu_b=0, alu_opcode=000. The ALU therefore sees stable inputs only in EXEC.
- Ordering and hazards:
  - Strict serial order: a write always completes before the next operand read, so there are no RAW hazards.
  - rs1==rs2 and rd==rs1 are legal; the read uses the pre-write value.
- wb_addr and wb_data hold their last value after the pulse. zero_flag holds until the next write.
- Arithmetic: 8-bit modulo, as produced by the ALU. The block neither extends nor saturates.
- dbg_data reflects the register contents after the edge. A write in WB is visible on dbg_data from the next cycle.
- instr_* inputs are ignored whenever instr_ready=0.

Test Plan:
- Reset: hold rst_n=0 mid-EXEC -> regs all 00, state IDLE, instr_ready=1, no wb_valid, illegal_op=0.
- Load immediates: ld_imm r0=0x3C then r1=0x0F -> wb_valid pulses with (0,0x3C) and (1,0x0F); the second instruction is accepted in the pulse cycle of the first; zero_flag=0.
- ALU ops with r0=0x3C, r1=0x0F, expected result on alu_result and in rd:
  - AND -> 0x0C
  - OR -> 0x3F
  - ADD -> 0x4B
  - SUB r1-r0 -> 0xD3
  - INC 0xFF -> 0x00 with zero_flag=1
  - DEC 0x00 -> 0xFF
- Self-operand: SUB r2 = r2 - r2 with r2=0x55 -> result 0x00, zero_flag=1; dbg_addr=2 reads 0x00 next cycle.
- Handshake: instr_valid held high continuously with 3 instructions -> accepted on cycles 0, 3, 6; inputs changed while instr_ready=0 have no effect.
- Illegal opcode 111 on a non-immediate instruction -> rd written 0x00, illegal_op=1 and stays 1 after later legal ops until rst_n=0.

Source files
------------

// File: rtl/alu_operand_regfile.sv
// Register file and IDLE/EXEC/WB sequencer feeding a combinational ALU.
// One instruction per three cycles; write-back is reported with a one-cycle pulse.
module alu_operand_regfile #(
  parameter int NUM_REGS = 4,
  parameter int AW       = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic          instr_ld_imm,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs1,
  input  logic [AW-1:0] instr_rs2,
  input  logic [7:0]    instr_imm,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [7:0]    alu_result,
  output logic          wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [7:0]    wb_data,
  output logic          zero_flag,
  output logic          illegal_op,
  input  logic [AW-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    regs_q [NUM_REGS];
  logic          ld_imm_q;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [7:0]    imm_q, result_q;
  logic          wb_valid_q, zero_q, illegal_q;
  logic [AW-1:0] wb_addr_q;
  logic [7:0]    wb_data_q;
  logic          accept;

  assign accept = instr_valid && instr_ready;

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_opcode  = 3'b000;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: begin
        alu_a      = regs_q[rs1_q];
        alu_b      = regs_q[rs2_q];
        alu_opcode = op_q;
        state_d    = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ld_imm_q   <= 1'b0;
      op_q       <= 3'b000;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      imm_q      <= 8'h00;
      result_q   <= 8'h00;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= 8'h00;
      zero_q     <= 1'b0;
      illegal_q  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= 1'b0;
      if (accept) begin
        ld_imm_q <= instr_ld_imm;
        op_q     <= instr_op;
        rd_q     <= instr_rd;
        rs1_q    <= instr_rs1;
        rs2_q    <= instr_rs2;
        imm_q    <= instr_imm;
      end
      if (state_q == EXEC) begin
        result_q <= ld_imm_q ? imm_q : alu_result;
        // Opcodes 110/111 only count as illegal on the ALU path.
        if (!ld_imm_q && op_q[2] && op_q[1])
          illegal_q <= 1'b1;
      end
      if (state_q == WB) begin
        regs_q[rd_q] <= result_q;
        wb_valid_q   <= 1'b1;
        wb_addr_q    <= rd_q;
        wb_data_q    <= result_q;
        zero_q       <= (result_q == 8'h00);
      end
    end
  end

  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = wb_data_q;
  assign zero_flag  = zero_q;
  assign illegal_op = illegal_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_operand_regfile.sv
// Scoreboard bench for alu_operand_regfile with an attached ALU model.
// Expected write-backs are queued at issue and checked by a separate monitor.
module tb_alu_operand_regfile;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       instr_valid = 0;
  logic       instr_ready;
  logic       instr_ld_imm = 0;
  logic [2:0] instr_op = 0;
  logic [1:0] instr_rd = 0, instr_rs1 = 0, instr_rs2 = 0;
  logic [7:0] instr_imm = 0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_opcode;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       zero_flag, illegal_op;
  logic [1:0] dbg_addr = 0;
  logic [7:0] dbg_data;

  alu_operand_regfile #(.NUM_REGS(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_ld_imm(instr_ld_imm), .instr_op(instr_op),
    .instr_rd(instr_rd), .instr_rs1(instr_rs1),
    .instr_rs2(instr_rs2), .instr_imm(instr_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .zero_flag(zero_flag), .illegal_op(illegal_op),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_fn(
    input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return a + 8'd1;
      3'd5: return a - 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [1:0] addr;
    logic [7:0] data;
    logic       ill;
  } exp_t;

  exp_t       q[$];
  logic [7:0] m [4];
  logic       ill_m;
  int         tests = 0, fails = 0;
  int         cyc = 0;
  int         acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("wb_addr", wb_addr, e.addr);
        chk("wb_data", wb_data, e.data);
        chk("zero_flag", zero_flag, e.data == 8'h00);
        chk("illegal_op", illegal_op, e.ill);
      end
    end
    if (rst_n && instr_ready)
      chk("alu_idle_zero", {alu_a, alu_b, 5'(alu_opcode)}, 0);
  end

  task automatic issue(input logic ld, input logic [2:0] op,
                       input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic [7:0] imm);
    int  n;
    bit  done;
    exp_t e;
    n = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      instr_valid = 1;
      if (instr_ready) begin
        instr_ld_imm = ld; instr_op = op; instr_rd = rd;
        instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
        acc_cyc = cyc;
        @(posedge clk);
        e.data = ld ? imm : alu_fn(op, m[rs1], m[rs2]);
        e.addr = rd;
        if (!ld && op >= 3'd6) ill_m = 1;
        e.ill = ill_m;
        m[rd] = e.data;
        q.push_back(e);
        done = 1;
      end else begin
        instr_ld_imm = 1'($urandom); instr_op = 3'($urandom);
        instr_rd = 2'($urandom); instr_rs1 = 2'($urandom);
        instr_rs2 = 2'($urandom); instr_imm = 8'($urandom);
        n++;
        if (n > 20) begin
          chk("ready_timeout", 0, 1);
          done = 1;
        end
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    instr_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 0);
    @(negedge clk);
  endtask

  task automatic check_regs(input string nm);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(nm, dbg_data, m[i]);
    end
  endtask

  task automatic reset_model();
    q.delete();
    ill_m = 0;
    for (int i = 0; i < 4; i++) m[i] = 8'h00;
  endtask

  initial begin
    int a0, a1;
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_ready", instr_ready, 1);
    chk("rst_wb", {wb_valid, wb_addr, wb_data}, 0);
    chk("rst_flags", {zero_flag, illegal_op}, 0);
    rst_n = 1;
    check_regs("rst_regs");

    issue(1, 0, 1, 0, 0, 8'hAA);
    idle();
    drain();
    issue(1, 0, 2, 0, 0, 8'h77);
    @(negedge clk);
    rst_n = 0;
    reset_model();
    #1;
    chk("midrst_ready", instr_ready, 1);
    chk("midrst_wb", wb_valid, 0);
    instr_valid = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    check_regs("midrst_regs");
    repeat (4) @(negedge clk);
    chk("midrst_ill", illegal_op, 0);

    issue(1, 0, 0, 0, 0, 8'h3C);
    a0 = acc_cyc;
    issue(1, 0, 1, 0, 0, 8'h0F);
    a1 = acc_cyc;
    chk("ld_gap", a1 - a0, 3);
    issue(0, 0, 2, 0, 1, 0);
    issue(0, 1, 2, 0, 1, 0);
    issue(0, 2, 2, 0, 1, 0);
    issue(0, 3, 3, 1, 0, 0);
    issue(1, 0, 2, 0, 0, 8'hFF);
    issue(0, 4, 2, 2, 0, 0);
    issue(0, 5, 3, 2, 0, 0);
    issue(1, 0, 2, 0, 0, 8'h55);
    issue(0, 3, 2, 2, 2, 0);
    idle();
    drain();
    chk("self_sub_zf", zero_flag, 1);
    check_regs("dir_regs");
    chk("r3_dec", m[3], 8'hFF);

    issue(1, 0, 0, 0, 0, 8'h10);
    a0 = acc_cyc;
    issue(0, 2, 1, 0, 0, 0);
    a1 = acc_cyc;
    chk("burst_gap1", a1 - a0, 3);
    issue(0, 4, 1, 1, 0, 0);
    chk("burst_gap2", acc_cyc - a0, 6);
    idle();
    drain();
    check_regs("burst_regs");

    for (int k = 0; k < 150; k++)
      issue(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 5)),
            2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    idle();
    drain();
    check_regs("rand_regs");
    chk("rand_ill", illegal_op, 0);

    issue(1, 0, 3, 0, 0, 8'h99);
    issue(0, 7, 3, 0, 1, 0);
    issue(0, 1, 2, 0, 1, 0);
    issue(1, 6, 1, 0, 0, 8'h42);
    for (int k = 0; k < 30; k++)
      issue(1'($urandom), 3'($urandom),
            2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom));
    idle();
    drain();
    chk("ill_sticky", illegal_op, 1);
    check_regs("ill_regs");

    rst_n = 0;
    reset_model();
    #1;
    chk("final_rst_ill", illegal_op, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
